// File: rtl/irig_b_pkg.sv
// Shared IRIG-B definitions: symbol encoding, pulse widths, bit period and P marker positions.
package irig_b_pkg;

  // Encoding matches the receive-side pulse classifier
  typedef enum logic [2:0] {
    SYM_L = 3'b001,
    SYM_P = 3'b010,
    SYM_H = 3'b100
  } sym_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  localparam int P_MS       = 8;
  localparam int H_MS       = 5;
  localparam int L_MS       = 2;
  localparam int BIT_MS     = 10;
  localparam int FRAME_BITS = 100;

  localparam logic [6:0] P_IDX [11] = '{7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
                                        7'd59, 7'd69, 7'd79, 7'd89, 7'd99};

  function automatic logic is_p(input logic [6:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 11; i++)
      if (idx == P_IDX[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [3:0] width_ms(input sym_t s);
    logic [3:0] w;
    case (s)
      SYM_P:   w = 4'(P_MS);
      SYM_H:   w = 4'(H_MS);
      default: w = 4'(L_MS);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/irig_b_tx_sym.sv
// Per-bit IRIG-B symbol selection from bit index and latched BCD time.
// Optional straight-binary-seconds field in bits 80-97 when IRIGB_TX_SBS_EN is defined.
module irig_b_tx_sym
  import irig_b_pkg::*;
(
  input  logic [6:0] bit_idx,
  input  logic [6:0] second,
  input  logic [6:0] minute,
  input  logic [5:0] hour,
  input  logic [9:0] doy,
  input  logic [7:0] year,
  output sym_t       sym
);

  logic [99:0] data;
`ifdef IRIGB_TX_SBS_EN
  logic [16:0] sbs;
`endif

  always_comb begin
    data = '0;
    data[4:1]   = second[3:0];
    data[8:6]   = second[6:4];
    data[13:10] = minute[3:0];
    data[17:15] = minute[6:4];
    data[23:20] = hour[3:0];
    data[26:25] = hour[5:4];
    data[33:30] = doy[3:0];
    data[38:35] = doy[7:4];
    data[41:40] = doy[9:8];
    data[53:50] = year[3:0];
    data[58:55] = year[7:4];
`ifdef IRIGB_TX_SBS_EN
    // Digits are used as-is, so invalid BCD yields a wrapped but deterministic value
    sbs = (17'(hour[5:4]) * 17'd10 + 17'(hour[3:0])) * 17'd3600
        + (17'(minute[6:4]) * 17'd10 + 17'(minute[3:0])) * 17'd60
        + 17'(second[6:4]) * 17'd10 + 17'(second[3:0]);
    data[88:80] = sbs[8:0];
    data[97:90] = sbs[16:9];
`endif
    sym = SYM_L;
    if (is_p(bit_idx))
      sym = SYM_P;
    else if (data[bit_idx])
      sym = SYM_H;
  end

endmodule

// File: rtl/irig_b_tx.sv
// IRIG-B DC level-code transmitter: one 100-bit frame per pps_in rising edge.
// Define IRIGB_TX_SBS_EN to carry straight binary seconds of day in bits 80-97.
module irig_b_tx
  import irig_b_pkg::*;
#(
  parameter int CLK_FREQ = 125000000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       pps_in,
  input  logic [6:0] TxSecond,
  input  logic [6:0] TxMinute,
  input  logic [5:0] TxHour,
  input  logic [9:0] TxDayOfYear,
  input  logic [7:0] TxYear,
  output logic       IrigbOut,
  output logic       Tx_busy,
  output logic       Frame_done
);

  localparam int DIV   = CLK_FREQ / 1000;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cyc, cyc_nxt;
  logic [3:0]       ms, ms_nxt;
  logic [6:0]       bit_idx, bit_nxt;
  logic             pps_d, pps_rise, tick;
  logic [6:0]       lat_sec, lat_min;
  logic [5:0]       lat_hour;
  logic [9:0]       lat_doy;
  logic [7:0]       lat_year;
  sym_t             sym;

  assign pps_rise = pps_in & ~pps_d;
  assign tick     = (cyc == CNT_W'(DIV - 1));

  // pps_d resets high so a pps_in already high at reset release is not an edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      cyc      <= '0;
      ms       <= '0;
      bit_idx  <= '0;
      pps_d    <= 1'b1;
      lat_sec  <= '0;
      lat_min  <= '0;
      lat_hour <= '0;
      lat_doy  <= '0;
      lat_year <= '0;
    end else begin
      state   <= state_nxt;
      cyc     <= cyc_nxt;
      ms      <= ms_nxt;
      bit_idx <= bit_nxt;
      pps_d   <= pps_in;
      if (pps_rise) begin
        lat_sec  <= TxSecond;
        lat_min  <= TxMinute;
        lat_hour <= TxHour;
        lat_doy  <= TxDayOfYear;
        lat_year <= TxYear;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cyc_nxt    = cyc;
    ms_nxt     = ms;
    bit_nxt    = bit_idx;
    Frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pps_rise) begin
          state_nxt = ST_SEND;
          cyc_nxt   = '0;
          ms_nxt    = '0;
          bit_nxt   = '0;
        end
      end
      ST_SEND: begin
        // A new edge always wins, including on the final cycle of bit 99
        if (pps_rise) begin
          cyc_nxt = '0;
          ms_nxt  = '0;
          bit_nxt = '0;
        end else begin
          cyc_nxt = tick ? '0 : cyc + CNT_W'(1);
          if (tick) begin
            if (ms == 4'(BIT_MS - 1)) begin
              ms_nxt = '0;
              if (bit_idx == 7'(FRAME_BITS - 1)) begin
                state_nxt  = ST_IDLE;
                bit_nxt    = '0;
                Frame_done = 1'b1;
              end else begin
                bit_nxt = bit_idx + 7'd1;
              end
            end else begin
              ms_nxt = ms + 4'd1;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  irig_b_tx_sym u_sym (
    .bit_idx (bit_idx),
    .second  (lat_sec),
    .minute  (lat_min),
    .hour    (lat_hour),
    .doy     (lat_doy),
    .year    (lat_year),
    .sym     (sym)
  );

  assign Tx_busy  = (state == ST_SEND);
  assign IrigbOut = Tx_busy && (ms < width_ms(sym));

endmodule
